// File: rtl/kahan_accum_pkg.sv
// Shared types and helpers for the compensated-sum block sequencer.
package kahan_accum_pkg;

    // Lane tags carry enough bits for up to 16 interleaved lanes.
    localparam int unsigned TAG_LANE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_REDUCE,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic                  valid;
        logic [TAG_LANE_W-1:0] lane;
    } tag_t;

    function automatic int unsigned calc_bit_width(input int unsigned exp_w,
                                                   input int unsigned mant_w);
        return 1 + exp_w + mant_w;
    endfunction

    // Operand is right-aligned in 64 bits; width selects which bit is the sign.
    function automatic logic [63:0] fp_neg(input logic [63:0] x, input int unsigned width);
        return x ^ (64'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/kahan_tag_pipe.sv
// Delay line of issue tags matching the feedback latency of the step unit.
module kahan_tag_pipe
    import kahan_accum_pkg::*;
#(
    parameter int unsigned STEP_LAT = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t pipe_q [STEP_LAT];
    tag_t pipe_d [STEP_LAT];

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = tag_i;
        for (int i = 1; i < STEP_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STEP_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_o = pipe_q[STEP_LAT-1];

endmodule

// File: rtl/kahan_accum_ctrl.sv
// Streams a block of elements through a shared pipelined Kahan step using
// STEP_LAT interleaved lane partials, then folds the lanes into one (sum, c).
module kahan_accum_ctrl
    import kahan_accum_pkg::*;
#(
    parameter int unsigned EXP_WIDTH_I  = 5,
    parameter int unsigned MANT_WIDTH_I = 2,
    parameter int unsigned STEP_LAT     = 2,
    localparam int unsigned BIT_WIDTH_I = calc_bit_width(EXP_WIDTH_I, MANT_WIDTH_I)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [BIT_WIDTH_I-1:0] in_data_i,
    input  logic                   in_last_i,
    output logic [BIT_WIDTH_I-1:0] step_elem_o,
    output logic [BIT_WIDTH_I-1:0] step_sum_o,
    output logic [BIT_WIDTH_I-1:0] step_c_o,
    output logic                   step_issue_o,
    input  logic [BIT_WIDTH_I-1:0] step_sum_i,
    input  logic [BIT_WIDTH_I-1:0] step_c_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [BIT_WIDTH_I-1:0] res_sum_o,
    output logic [BIT_WIDTH_I-1:0] res_c_o,
    output logic                   busy_o
);

    localparam int unsigned           RED_CYC   = 2 * (STEP_LAT - 1) * STEP_LAT;
    localparam logic [TAG_LANE_W-1:0] LAST_LANE = TAG_LANE_W'(STEP_LAT - 1);

    typedef logic [BIT_WIDTH_I-1:0] elem_t;

    state_e                state_q, state_d;
    logic [TAG_LANE_W-1:0] ptr_q, ptr_d;
    logic [TAG_LANE_W-1:0] wait_q, wait_d;
    logic [TAG_LANE_W-1:0] k_q, k_d;
    logic                  phase_q, phase_d;
    logic [15:0]           red_q, red_d;
    elem_t                 psum_q [STEP_LAT];
    elem_t                 psum_d [STEP_LAT];
    elem_t                 pc_q   [STEP_LAT];
    elem_t                 pc_d   [STEP_LAT];
    elem_t                 acc_q, acc_d, acc_c_q, acc_c_d;

    tag_t  tag_in, tag_ret;
    logic  ret_lane, ret_acc;
    elem_t lane_sum, lane_c, k_sum, k_c, acc_now, acc_c_now;

    kahan_tag_pipe #(.STEP_LAT(STEP_LAT)) u_tag_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tag_i  (tag_in),
        .tag_o  (tag_ret)
    );

    always_comb begin
        ret_lane = tag_ret.valid && (state_q == ST_ACCUM || state_q == ST_DRAIN);
        ret_acc  = tag_ret.valid && (state_q == ST_REDUCE || state_q == ST_DONE);

        lane_sum = '0;
        lane_c   = '0;
        k_sum    = '0;
        k_c      = '0;
        for (int l = 0; l < STEP_LAT; l++) begin
            if (ptr_q == TAG_LANE_W'(l)) begin
                lane_sum = psum_q[l];
                lane_c   = pc_q[l];
            end
            if (k_q == TAG_LANE_W'(l)) begin
                k_sum = psum_q[l];
                k_c   = pc_q[l];
            end
        end
        // A lane being reissued in the same cycle its previous result lands
        if (ret_lane && tag_ret.lane == ptr_q) begin
            lane_sum = step_sum_i;
            lane_c   = step_c_i;
        end
        acc_now   = ret_acc ? step_sum_i : acc_q;
        acc_c_now = ret_acc ? step_c_i   : acc_c_q;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = '0;
        wait_d  = wait_q;
        k_d     = k_q;
        phase_d = phase_q;
        red_d   = red_q;
        psum_d  = psum_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        acc_c_d = acc_c_q;

        in_ready_o   = 1'b0;
        step_issue_o = 1'b0;
        step_elem_o  = '0;
        step_sum_o   = '0;
        step_c_o     = '0;
        res_valid_o  = 1'b0;
        res_sum_o    = '0;
        res_c_o      = '0;

        if (ret_lane) begin
            for (int l = 0; l < STEP_LAT; l++) begin
                if (tag_ret.lane == TAG_LANE_W'(l)) begin
                    psum_d[l] = step_sum_i;
                    pc_d[l]   = step_c_i;
                end
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                // Masked by reset so every output reads 0 while rst_ni is low.
                in_ready_o = rst_ni;
                if (in_valid_i && in_ready_o) begin
                    for (int l = 0; l < STEP_LAT; l++) begin
                        psum_d[l] = '0;
                        pc_d[l]   = '0;
                    end
                    step_issue_o = 1'b1;
                    step_elem_o  = in_data_i;
                    ptr_d        = (LAST_LANE == '0) ? '0 : TAG_LANE_W'(1);
                    if (in_last_i) begin
                        state_d = ST_DRAIN;
                        wait_d  = LAST_LANE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                in_ready_o = 1'b1;
                ptr_d      = (ptr_q == LAST_LANE) ? '0 : ptr_q + 1'b1;
                if (in_valid_i) begin
                    step_issue_o = 1'b1;
                    step_elem_o  = in_data_i;
                    step_sum_o   = lane_sum;
                    step_c_o     = lane_c;
                    if (in_last_i) begin
                        state_d = ST_DRAIN;
                        wait_d  = LAST_LANE;
                    end
                end
            end
            ST_DRAIN: begin
                if (wait_q == '0) begin
                    acc_d   = psum_d[0];
                    acc_c_d = pc_d[0];
                    k_d     = TAG_LANE_W'(1);
                    phase_d = 1'b0;
                    wait_d  = '0;
                    red_d   = 16'(RED_CYC - 1);
                    state_d = (STEP_LAT > 1) ? ST_REDUCE : ST_DONE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_REDUCE: begin
                acc_d   = acc_now;
                acc_c_d = acc_c_now;
                red_d   = red_q - 16'd1;
                if (wait_q == '0) begin
                    step_issue_o = 1'b1;
                    step_elem_o  = phase_q ? BIT_WIDTH_I'(fp_neg(64'(k_c), BIT_WIDTH_I)) : k_sum;
                    step_sum_o   = acc_now;
                    step_c_o     = acc_c_now;
                    wait_d       = LAST_LANE;
                    phase_d      = ~phase_q;
                    if (phase_q) begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
                if (red_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                acc_d       = acc_now;
                acc_c_d     = acc_c_now;
                res_valid_o = 1'b1;
                res_sum_o   = acc_now;
                res_c_o     = acc_c_now;
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tag_in.valid = step_issue_o;
        tag_in.lane  = (state_q == ST_ACCUM) ? ptr_q : '0;
    end

    assign busy_o = (state_q != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            wait_q  <= '0;
            k_q     <= '0;
            phase_q <= 1'b0;
            red_q   <= '0;
            acc_q   <= '0;
            acc_c_q <= '0;
            for (int l = 0; l < STEP_LAT; l++) begin
                psum_q[l] <= '0;
                pc_q[l]   <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wait_q  <= wait_d;
            k_q     <= k_d;
            phase_q <= phase_d;
            red_q   <= red_d;
            acc_q   <= acc_d;
            acc_c_q <= acc_c_d;
            psum_q  <= psum_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_kahan_accum_ctrl.sv
// Bench for kahan_accum_ctrl (E5M2, two lanes) with a behavioural step unit
// and a scoreboard of expected (sum, c, rise cycle) built from a Kahan model.
module tb_kahan_accum_ctrl;

    localparam int LAT = 2;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [7:0] in_data_i = 8'h00;
    logic       in_last_i = 1'b0;
    logic [7:0] step_elem_o, step_sum_o, step_c_o;
    logic       step_issue_o;
    logic [7:0] step_sum_i, step_c_i;
    logic       res_valid_o;
    logic       res_ready_i = 1'b1;
    logic [7:0] res_sum_o, res_c_o;
    logic       busy_o;

    always #5 clk_i = ~clk_i;

    kahan_accum_ctrl #(.EXP_WIDTH_I(5), .MANT_WIDTH_I(2), .STEP_LAT(LAT)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .in_last_i    (in_last_i),
        .step_elem_o  (step_elem_o),
        .step_sum_o   (step_sum_o),
        .step_c_o     (step_c_o),
        .step_issue_o (step_issue_o),
        .step_sum_i   (step_sum_i),
        .step_c_i     (step_c_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_sum_o    (res_sum_o),
        .res_c_o      (res_c_o),
        .busy_o       (busy_o)
    );

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp_dec(input logic [7:0] b);
        int  e = int'(b[6:2]);
        real m = real'(int'(b[1:0])) / 4.0;
        real v;
        v = (e == 0) ? m * pow2(-14) : (1.0 + m) * pow2(e - 15);
        return b[7] ? -v : v;
    endfunction

    function automatic logic [7:0] fp_enc(input real x);
        logic s;
        real  a, r, fr;
        int   e, be, q;
        if (x == 0.0) return 8'h00;
        s = (x < 0.0);
        a = s ? -x : x;
        if (a < pow2(-14)) begin
            be = 0;
            r  = a * pow2(16);
        end else begin
            e = -14;
            while (e < 16 && a >= pow2(e + 1)) e++;
            be = e + 15;
            r  = (a / pow2(e) - 1.0) * 4.0;
        end
        q  = $rtoi(r);
        fr = r - real'(q);
        if (fr > 0.5 || (fr == 0.5 && q[0])) q++;
        if (q == 4) begin
            q = 0;
            be++;
        end
        if (be >= 31) return {s, 7'h7C};
        return {s, be[4:0], q[1:0]};
    endfunction

    function automatic real rnd(input real x);
        return fp_dec(fp_enc(x));
    endfunction

    // Returns {sum_o, c_o} of one compensated step with E5M2 rounding after each op.
    function automatic logic [15:0] kahan_fn(input logic [7:0] e, input logic [7:0] s,
                                             input logic [7:0] c);
        real y, t, cn;
        y  = rnd(fp_dec(e) - fp_dec(c));
        t  = rnd(fp_dec(s) + y);
        cn = rnd(rnd(t - fp_dec(s)) - y);
        return {fp_enc(t), fp_enc(cn)};
    endfunction

    // Behavioural step unit: result visible LAT cycles after issue.
    logic [15:0] sp_q [LAT];
    always @(posedge clk_i) begin
        sp_q[0] <= kahan_fn(step_elem_o, step_sum_o, step_c_o);
        for (int i = 1; i < LAT; i++) sp_q[i] <= sp_q[i-1];
    end
    assign step_sum_i = sp_q[LAT-1][15:8];
    assign step_c_i   = sp_q[LAT-1][7:0];

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] sum;
        logic [7:0] c;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    exp_t mon_e;
    logic res_seen = 1'b0;

    initial forever begin
        @(negedge clk_i);
        if (res_valid_o && !res_seen) begin
            if (exp_q.size() == 0) begin
                chk("res_unexpected", 32'(res_valid_o), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_sum", 32'(res_sum_o), 32'(mon_e.sum));
                chk("res_c", 32'(res_c_o), 32'(mon_e.c));
                chk("res_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        res_seen = res_valid_o;
    end

    logic       pat_v [4];
    logic [7:0] pat_d [4];

    task automatic set_pat(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
        pat_v[0] = v[0]; pat_v[1] = v[1]; pat_v[2] = v[2]; pat_v[3] = v[3];
        pat_d[0] = d0;   pat_d[1] = d1;   pat_d[2] = d2;   pat_d[3] = d3;
    endtask

    // Called at posedge+1 with the controller idle; lane of slot i is i mod LAT.
    task automatic drive_block(input int len);
        logic [7:0]  ls [LAT];
        logic [7:0]  lc [LAT];
        logic [15:0] r;
        logic [7:0]  acc, acc_c;
        int          start, ln;
        exp_t        e;
        for (int l = 0; l < LAT; l++) begin
            ls[l] = 8'h00;
            lc[l] = 8'h00;
        end
        start = cyc;
        for (int i = 0; i < len; i++) begin
            in_valid_i = pat_v[i];
            in_data_i  = pat_d[i];
            in_last_i  = (i == len - 1);
            ln = i % LAT;
            if (pat_v[i]) begin
                r      = kahan_fn(pat_d[i], ls[ln], lc[ln]);
                ls[ln] = r[15:8];
                lc[ln] = r[7:0];
            end
            @(negedge clk_i);
            chk("in_ready_accum", 32'(in_ready_o), 32'd1);
            if (!pat_v[i]) chk("bubble_issue", 32'(step_issue_o), 32'd0);
            @(posedge clk_i);
            #1;
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        in_data_i  = 8'h00;
        acc   = ls[0];
        acc_c = lc[0];
        for (int k = 1; k < LAT; k++) begin
            r     = kahan_fn(ls[k], acc, acc_c);
            acc   = r[15:8];
            acc_c = r[7:0];
            r     = kahan_fn({~lc[k][7], lc[k][6:0]}, acc, acc_c);
            acc   = r[15:8];
            acc_c = r[7:0];
        end
        e.sum = acc;
        e.c   = acc_c;
        e.cyc = start + (len - 1) + LAT + 2 * (LAT - 1) * LAT + 1;
        exp_q.push_back(e);
        last_exp = e;
    endtask

    // Waits for res_valid_o; with res_ready_i high the handshake completes before return.
    task automatic wait_result(input string tag);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!res_valid_o && n < 100);
        if (!res_valid_o) chk({tag, "_timeout"}, 32'd0, 32'd1);
        if (res_ready_i) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_res_valid", 32'(res_valid_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_issue", 32'(step_issue_o), 32'd0);
        chk("rst_res_sum", 32'(res_sum_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Four ones back-to-back
        set_pat(4'b1111, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
        drive_block(4);
        wait_result("four_ones");
        chk("four_ones_sum_const", 32'(last_exp.sum), 32'h44);

        // Single element straight from IDLE into DRAIN
        set_pat(4'b0001, 8'h40, 8'h00, 8'h00, 8'h00);
        drive_block(1);
        @(negedge clk_i);
        chk("single_drain_ready", 32'(in_ready_o), 32'd0);
        chk("single_drain_busy", 32'(busy_o), 32'd1);
        @(posedge clk_i);
        #1;
        wait_result("single");

        // Bubble in slot 1
        set_pat(4'b1101, 8'h3C, 8'h00, 8'h3C, 8'h3C);
        drive_block(4);
        wait_result("bubble");
        chk("bubble_sum_const", 32'(last_exp.sum), 32'h42);

        // Back-pressure in DONE
        res_ready_i = 1'b0;
        set_pat(4'b1111, 8'h3C, 8'h40, 8'h3C, 8'h3C);
        drive_block(4);
        wait_result("hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("hold_valid", 32'(res_valid_o), 32'd1);
            chk("hold_sum", 32'(res_sum_o), 32'(last_exp.sum));
            chk("hold_c", 32'(res_c_o), 32'(last_exp.c));
            chk("hold_in_ready", 32'(in_ready_o), 32'd0);
        end
        @(posedge clk_i);
        #1 res_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("post_hs_in_ready", 32'(in_ready_o), 32'd1);
        chk("post_hs_busy", 32'(busy_o), 32'd0);
        chk("post_hs_valid", 32'(res_valid_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Asynchronous reset in REDUCE, then a clean block
        set_pat(4'b1111, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
        drive_block(4);
        repeat (3) @(posedge clk_i);
        #1;
        chk("reduce_busy", 32'(busy_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_ctrl", 32'({in_ready_o, busy_o, res_valid_o, step_issue_o}), 32'd0);
        chk("arst_step", 32'({step_elem_o, step_sum_o, step_c_o}), 32'd0);
        chk("arst_res", 32'({res_sum_o, res_c_o}), 32'd0);
        exp_q.delete();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        set_pat(4'b0011, 8'h3C, 8'h3C, 8'h00, 8'h00);
        drive_block(2);
        wait_result("after_reset");
        chk("after_reset_sum_const", 32'(last_exp.sum), 32'h40);

        // Cancellation
        set_pat(4'b1111, 8'h3C, 8'hBC, 8'h3C, 8'hBC);
        drive_block(4);
        wait_result("cancel");

        repeat (2) @(posedge clk_i);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/kahan_accum_ctrl.md
Name: kahan_accum_ctrl

Overview:
- Sequencer that streams an arbitrary-length block of FP elements through one shared, pipelined kahan_step unit and returns one compensated (sum, c) pair per block.
- The step unit has feedback latency STEP_LAT, so the controller interleaves STEP_LAT lane partials during accumulation, then serially reduces the lanes into one result.
- Sits between an element producer (valid/ready + last) and a result consumer (valid/ready). The step unit is external; the kahan_accum_top wrapper connects the two.

Parameters:
- EXP_WIDTH_I, 5, exponent width of the element format.
- MANT_WIDTH_I, 2, mantissa width of the element format.
- STEP_LAT, 2, cycles from step_*_o issue to step_sum_i/step_c_i valid. Must be ≥ 1. The lane count equals STEP_LAT.
- BIT_WIDTH_I (localparam), 1+EXP_WIDTH_I+MANT_WIDTH_I, element width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  element valid.
- in_ready_o  out  1  element accepted when in_valid_i && in_ready_o.
- in_data_i  in  BIT_WIDTH_I  element.
- in_last_i  in  1  marks the final element of a block.
- step_elem_o  out  BIT_WIDTH_I  step operand elem_i.
- step_sum_o  out  BIT_WIDTH_I  step operand sum_i.
- step_c_o  out  BIT_WIDTH_I  step operand c_i.
- step_issue_o  out  1  operands are meaningful this cycle (debug/power gating).
- step_sum_i  in  BIT_WIDTH_I  step sum_o.
- step_c_i  in  BIT_WIDTH_I  step c_o.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result accepted.
- res_sum_o  out  BIT_WIDTH_I  final sum.
- res_c_o  out  BIT_WIDTH_I  final compensation.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE; all outputs 0; lane regs psum[], pc[] = 0; tag pipe cleared.
  - Reset mid-block discards everything, including in-flight step results.
- Tag pipe: STEP_LAT-deep shift of {valid, lane}, pushed every cycle. A return is used only when its tag is valid.
- States: IDLE, ACCUM, DRAIN, REDUCE, DONE.
- IDLE: in_ready_o=1.
  - On accept: clear psum/pc, lane ptr=0, issue to lane 0, go to ACCUM.
  - If in_last_i is also set, go to DRAIN instead.
- ACCUM: in_ready_o=1.
  - Lane ptr advances mod STEP_LAT every cycle, including bubbles (no valid input).
  - On accept: issue elem=in_data_i, sum=psum[ptr], c=pc[ptr].
  - Bypass: if the returning tag lane == ptr, use step_sum_i/step_c_i instead of the registers.
  - Every valid return writes psum/pc[lane].
  - Accept with in_last_i: go to DRAIN.
- DRAIN: in_ready_o=0. Hold exactly STEP_LAT cycles while all in-flight returns are written back, then go to REDUCE.
- REDUCE: in_ready_o=0.
  - Initialise acc=psum[0], acc_c=pc[0].
  - For k=1..STEP_LAT-1, issue two dependent steps, each waiting STEP_LAT cycles for its return:
    - step 1: elem=psum[k], sum=acc, c=acc_c;
    - step 2: elem=-pc[k] (sign bit inverted), sum=acc, c=acc_c.
  - Each return updates acc/acc_c.
  - Total REDUCE duration: 2·(STEP_LAT−1)·STEP_LAT cycles. When STEP_LAT=1, zero cycles.
- DONE: res_valid_o=1, res_sum_o=acc, res_c_o=acc_c; outputs held stable until res_ready_i.
  - On the handshake: go to IDLE.
  - in_ready_o=0 in DONE, so a new block is accepted at the earliest the cycle after the handshake.
- Latency: with N elements accepted back-to-back from cycle 0, res_valid_o rises at cycle N−1+STEP_LAT+2(STEP_LAT−1)STEP_LAT+1.
- Bubbles inside ACCUM add their count to this latency.
- step_issue_o=0 when no issue. Step operand outputs are then 0.

Decomposition:
- Package kahan_accum_pkg holds:
  - the state enum;
  - the BIT_WIDTH_I derivation;
  - the fp_neg function (sign-bit flip);
  - the tag struct {valid, lane}.
- Sub-module kahan_tag_pipe: a parameterised STEP_LAT shift register of tags with async reset.

Test Plan:
- E5M2, STEP_LAT=2; four elements 0x3C (1.0), last on the 4th, back-to-back from cycle 0 → res_valid_o at cycle 10, res_sum_o=0x44 (4.0), res_c_o=0x00.
- Single element 0x40 with in_last_i in IDLE → res_sum_o=0x40, res_c_o=0x00; DRAIN entered directly from IDLE.
- Bubble pattern valid,0,valid,valid (0x3C each, last on the 4th) → result 0x42 (3.0); latency grows by 1; no lost or duplicated lane writes.
- Hold res_ready_i=0 for 5 cycles in DONE → outputs stable, in_ready_o=0; handshake then gives IDLE and in_ready_o=1 next cycle.
- Assert rst_ni low during REDUCE → all outputs 0 immediately (asynchronously); a following block of two 0x3C yields 0x40, with no stale contribution.
- Cancellation: 0x3C, 0xBC, 0x3C, 0xBC → res_sum_o=0x00, res_c_o=0x00; checked against a scoreboard built from a Kahan model.
